// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the generic pipeline stage register.
package pipe_stage_reg_pkg;

  localparam int unsigned PIPE_ST_W = 2;

  // Occupancy-encoded states: the encoding doubles as the entry count.
  typedef enum logic [PIPE_ST_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_st_e;

  // addi x0, x0, 0 -- bubble value loaded on reset and flush.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Number of entries held in a given state.
  function automatic logic [PIPE_ST_W-1:0] st_occ(input pipe_st_e st);
    return PIPE_ST_W'(st);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter bit          SKID_EN = 1'b1,
  parameter logic [31:0] RST_VAL = INST_NOP,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [DW-1:0]    up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [DW-1:0]    dn_data_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [DW-1:0] RST_DW = DW'(RST_VAL);

  pipe_st_e         st_q;
  pipe_st_e         st_nxt;
  logic [DW-1:0]    m_q;
  logic [DW-1:0]    m_nxt;
  logic [DW-1:0]    s_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             up_fire;
  logic             dn_fire;

  assign up_fire     = up_valid_i & up_ready_o;
  assign dn_fire     = dn_valid_o & dn_ready_i;
  assign dn_valid_o  = (st_q != ST_EMPTY);
  assign occ_o       = st_occ(st_q);
  assign dn_data_o   = m_q;
  assign stall_cnt_o = stall_cnt_q;

  // Next state and main-register update; flush overrides every transfer.
  always_comb begin
    st_nxt = st_q;
    m_nxt  = m_q;
    if (flush_i) begin
      st_nxt = ST_EMPTY;
      m_nxt  = RST_DW;
    end else begin
      unique case (st_q)
        ST_EMPTY: begin
          if (up_fire) begin
            st_nxt = ST_ONE;
            m_nxt  = up_data_i;
          end
        end
        ST_ONE: begin
          if (up_fire && dn_fire) begin
            m_nxt = up_data_i;
          end else if (up_fire && SKID_EN) begin
            st_nxt = ST_TWO;
          end else if (dn_fire) begin
            st_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (dn_fire) begin
            st_nxt = ST_ONE;
            m_nxt  = s_q;
          end
        end
        default: begin
          st_nxt = ST_EMPTY;
          m_nxt  = RST_DW;
        end
      endcase
    end
  end

  // State and main payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_EMPTY;
      m_q  <= RST_DW;
    end else begin
      st_q <= st_nxt;
      m_q  <= m_nxt;
    end
  end

  // Stall-cycle counter: sticks at all-ones, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (dn_valid_o && !dn_ready_i && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  if (SKID_EN) begin : g_skid
    logic [DW-1:0] s_nxt;
    logic          rdy_q;

    // Skid entry captures the beat that arrives while M is stalled.
    always_comb begin
      s_nxt = s_q;
      if (flush_i) begin
        s_nxt = RST_DW;
      end else if ((st_q == ST_ONE) && up_fire && !dn_fire) begin
        s_nxt = up_data_i;
      end else if ((st_q == ST_TWO) && dn_fire) begin
        s_nxt = RST_DW;
      end
    end

    // Skid register and registered ready (low only while both entries are full).
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q   <= RST_DW;
        rdy_q <= 1'b0;
      end else begin
        s_q   <= s_nxt;
        rdy_q <= (st_nxt != ST_TWO);
      end
    end

    assign up_ready_o = rdy_q & ~flush_i;
  end else begin : g_no_skid
    logic rst_done_q;

    // Holds ready low while in reset and releases it on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rst_done_q <= 1'b0;
      end else begin
        rst_done_q <= 1'b1;
      end
    end

    assign s_q        = RST_DW;
    assign up_ready_o = rst_done_q & ~flush_i & (dn_ready_i | ~dn_valid_o);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid-buffered and a single-register instance driven
// side by side and compared against queue-based reference models.
module tb_pipe_stage_reg;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             s_flush, s_uv, s_dr, s_ur, s_dv;
  logic [DW-1:0]    s_data, s_dd;
  logic [1:0]       s_occ;
  logic [CNT_W-1:0] s_cnt;
  logic             n_flush, n_uv, n_dr, n_ur, n_dv;
  logic [DW-1:0]    n_data, n_dd;
  logic [1:0]       n_occ;
  logic [CNT_W-1:0] n_cnt;

  pipe_stage_reg #(.DW(DW), .SKID_EN(1'b1), .RST_VAL(32'h13), .CNT_W(CNT_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_i(s_flush), .up_valid_i(s_uv), .up_ready_o(s_ur),
    .up_data_i(s_data), .dn_valid_o(s_dv), .dn_ready_i(s_dr), .dn_data_o(s_dd),
    .occ_o(s_occ), .stall_cnt_o(s_cnt)
  );

  pipe_stage_reg #(.DW(DW), .SKID_EN(1'b0), .RST_VAL(32'h13), .CNT_W(CNT_W)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush_i(n_flush), .up_valid_i(n_uv), .up_ready_o(n_ur),
    .up_data_i(n_data), .dn_valid_o(n_dv), .dn_ready_i(n_dr), .dn_data_o(n_dd),
    .occ_o(n_occ), .stall_cnt_o(n_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a bounded FIFO per instance plus a saturating counter.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] nq[$];
  int sc = 0;
  int nc = 0;
  bit rdy_en = 1'b0;

  function automatic bit exp_ready(input bit sk);
    if (!rdy_en) return 1'b0;
    if (sk) return !s_flush && (sq.size() < 2);
    return !n_flush && ((nq.size() == 0) || n_dr);
  endfunction

  task automatic model_clear();
    sq.delete(); nq.delete(); sc = 0; nc = 0; rdy_en = 1'b0;
  endtask

  // Apply one clock edge's worth of transfers to the model.
  task automatic model_edge();
    bit sr, nr;
    if (!rst_n) begin
      model_clear();
      return;
    end
    sr = exp_ready(1'b1);
    nr = exp_ready(1'b0);
    if ((sq.size() > 0) && !s_dr && !s_flush && (sc < CMAX)) sc++;
    if ((nq.size() > 0) && !n_dr && !n_flush && (nc < CMAX)) nc++;
    if (s_flush) sq.delete();
    else begin
      if ((sq.size() > 0) && s_dr) void'(sq.pop_front());
      if (s_uv && sr) sq.push_back(s_data);
    end
    if (n_flush) nq.delete();
    else begin
      if ((nq.size() > 0) && n_dr) void'(nq.pop_front());
      if (n_uv && nr) nq.push_back(n_data);
    end
    rdy_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_flush = 1'b0; s_uv = 1'b0; s_dr = 1'b0; s_data = '0;
    n_flush = 1'b0; n_uv = 1'b0; n_dr = 1'b0; n_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    #1;
    n_checks++; if ({s_dv, s_occ, s_cnt, s_ur} !== 8'h0) $display("FAIL reset_init_skid: got dv/occ/cnt/ur=%b expected 0", {s_dv, s_occ, s_cnt, s_ur}); else n_pass++;
    n_checks++; if ({n_dv, n_occ, n_cnt, n_ur} !== 8'h0) $display("FAIL reset_init_noskid: got dv/occ/cnt/ur=%b expected 0", {n_dv, n_occ, n_cnt, n_ur}); else n_pass++;
    n_checks++; if (s_dd !== NOP) $display("FAIL reset_init_data: got %h expected %h", s_dd, NOP); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (s_ur !== 1'b0) $display("FAIL ready_before_first_edge: got %b expected 0", s_ur); else n_pass++;
    tick();
    #1;
    n_checks++; if ({s_ur, n_ur} !== 2'b11) $display("FAIL ready_after_reset: got %b expected 11", {s_ur, n_ur}); else n_pass++;
    // Fill the skid instance to two entries, then reset asynchronously mid-cycle.
    s_uv = 1'b1; s_data = 32'hAAAA_0001; n_uv = 1'b1; n_data = 32'h5555_0001;
    tick();
    s_data = 32'hAAAA_0002; n_uv = 1'b0;
    tick();
    s_uv = 1'b0;
    #1;
    n_checks++; if (s_occ !== 2'd2) $display("FAIL prefill_occ: got %0d expected 2", s_occ); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++; if ({s_dv, s_occ, s_cnt, s_ur} !== 8'h0) $display("FAIL async_reset_skid: got dv/occ/cnt/ur=%b expected 0", {s_dv, s_occ, s_cnt, s_ur}); else n_pass++;
    n_checks++; if (s_dd !== NOP) $display("FAIL async_reset_data: got %h expected %h", s_dd, NOP); else n_pass++;
    n_checks++; if ({n_dv, n_occ, n_cnt} !== 7'h0) $display("FAIL async_reset_noskid: got dv/occ/cnt=%b expected 0", {n_dv, n_occ, n_cnt}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    idle_inputs();
    s_uv = 1'b1; s_dr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_data = DW'(i);
      #1;
      n_checks++; if (s_ur !== 1'b1) $display("FAIL stream_ready[%0d]: got %b expected 1", i, s_ur); else n_pass++;
      if (i == 1) begin
        n_checks++; if (s_dv !== 1'b0) $display("FAIL stream_first_valid: got %b expected 0", s_dv); else n_pass++;
      end else begin
        n_checks++; if ({s_dv, s_dd} !== {1'b1, DW'(i - 1)}) $display("FAIL stream_data[%0d]: got v=%b d=%0h expected v=1 d=%0h", i, s_dv, s_dd, i - 1); else n_pass++;
      end
      tick();
    end
    s_uv = 1'b0;
    #1;
    n_checks++; if ({s_dv, s_dd} !== {1'b1, DW'(8)}) $display("FAIL stream_last: got v=%b d=%0h expected v=1 d=8", s_dv, s_dd); else n_pass++;
    tick();
    #1;
    n_checks++; if (s_occ !== 2'd0) $display("FAIL stream_drain_occ: got %0d expected 0", s_occ); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = 32'hA000_000A; b = 32'hB000_000B; c = 32'hC000_000C;
    idle_inputs();
    do_reset();
    s_uv = 1'b1; s_data = a; s_dr = 1'b0;
    #1;
    n_checks++; if (s_ur !== 1'b1) $display("FAIL bp_ready_a: got %b expected 1", s_ur); else n_pass++;
    tick();
    s_data = b;
    #1;
    n_checks++; if ({s_ur, s_occ, s_dd} !== {1'b1, 2'd1, a}) $display("FAIL bp_accept_b: got ur=%b occ=%0d d=%h expected ur=1 occ=1 d=%h", s_ur, s_occ, s_dd, a); else n_pass++;
    tick();
    s_data = c;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if ({s_ur, s_occ, s_dd} !== {1'b0, 2'd2, a}) $display("FAIL bp_full[%0d]: got ur=%b occ=%0d d=%h expected ur=0 occ=2 d=%h", k, s_ur, s_occ, s_dd, a); else n_pass++;
      tick();
    end
    s_dr = 1'b1;
    #1;
    n_checks++; if (s_cnt !== CNT_W'(3)) $display("FAIL bp_stall_cnt: got %0d expected 3", s_cnt); else n_pass++;
    n_checks++; if ({s_ur, s_dd} !== {1'b0, a}) $display("FAIL bp_deliver_a: got ur=%b d=%h expected ur=0 d=%h", s_ur, s_dd, a); else n_pass++;
    tick();
    #1;
    n_checks++; if ({s_ur, s_occ, s_dd} !== {1'b1, 2'd1, b}) $display("FAIL bp_deliver_b: got ur=%b occ=%0d d=%h expected ur=1 occ=1 d=%h", s_ur, s_occ, s_dd, b); else n_pass++;
    tick();
    s_uv = 1'b0;
    #1;
    n_checks++; if ({s_dv, s_occ, s_dd} !== {1'b1, 2'd1, c}) $display("FAIL bp_deliver_c: got v=%b occ=%0d d=%h expected v=1 occ=1 d=%h", s_dv, s_occ, s_dd, c); else n_pass++;
    tick();
    #1;
    n_checks++; if ({s_dv, s_occ, s_cnt} !== {1'b0, 2'd0, CNT_W'(3)}) $display("FAIL bp_drained: got v=%b occ=%0d cnt=%0d expected v=0 occ=0 cnt=3", s_dv, s_occ, s_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    logic [DW-1:0] c;
    c = 32'hC0FF_EE00;
    idle_inputs();
    s_uv = 1'b1; s_data = 32'h0000_00A1;
    tick();
    s_data = 32'h0000_00B2;
    tick();
    s_flush = 1'b1; s_data = c;
    #1;
    n_checks++; if ({s_ur, s_occ} !== {1'b0, 2'd2}) $display("FAIL flush_ready: got ur=%b occ=%0d expected ur=0 occ=2", s_ur, s_occ); else n_pass++;
    tick();
    s_flush = 1'b0;
    #1;
    n_checks++; if ({s_dv, s_occ, s_ur, s_dd} !== {1'b0, 2'd0, 1'b1, NOP}) $display("FAIL flush_empty: got v=%b occ=%0d ur=%b d=%h expected v=0 occ=0 ur=1 d=%h", s_dv, s_occ, s_ur, s_dd, NOP); else n_pass++;
    n_checks++; if (s_cnt !== CNT_W'(sc)) $display("FAIL flush_stall_cnt: got %0d expected %0d", s_cnt, sc); else n_pass++;
    tick();
    s_uv = 1'b0;
    #1;
    n_checks++; if ({s_dv, s_occ, s_dd} !== {1'b1, 2'd1, c}) $display("FAIL flush_then_accept: got v=%b occ=%0d d=%h expected v=1 occ=1 d=%h", s_dv, s_occ, s_dd, c); else n_pass++;
    s_dr = 1'b1;
    tick();
    // Flush while empty only blocks ready for that cycle.
    s_flush = 1'b1; s_uv = 1'b1;
    #1;
    n_checks++; if ({s_ur, s_occ} !== {1'b0, 2'd0}) $display("FAIL flush_empty_ready: got ur=%b occ=%0d expected ur=0 occ=0", s_ur, s_occ); else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_checks++; if ({s_dv, s_ur} !== 2'b01) $display("FAIL flush_empty_after: got v/ur=%b expected 01", {s_dv, s_ur}); else n_pass++;
  endtask

  task automatic test_noskid();
    idle_inputs();
    n_uv = 1'b1; n_data = 32'h1111_0000;
    #1;
    n_checks++; if (n_ur !== 1'b1) $display("FAIL ns_ready_empty: got %b expected 1", n_ur); else n_pass++;
    tick();
    n_data = 32'h1111_0001;
    #1;
    n_checks++; if ({n_ur, n_dd} !== {1'b0, 32'h1111_0000}) $display("FAIL ns_blocked: got ur=%b d=%h expected ur=0 d=11110000", n_ur, n_dd); else n_pass++;
    n_dr = 1'b1;
    #1;
    n_checks++; if (n_ur !== 1'b1) $display("FAIL ns_comb_ready: got %b expected 1", n_ur); else n_pass++;
    tick();
    for (int i = 2; i < 8; i++) begin
      n_data = 32'h1111_0000 + DW'(i);
      #1;
      n_checks++; if ({n_ur, n_dv, n_occ, n_dd} !== {1'b1, 1'b1, 2'd1, 32'h1111_0000 + DW'(i - 1)}) $display("FAIL ns_pass[%0d]: got ur=%b v=%b occ=%0d d=%h expected ur=1 v=1 occ=1 d=%h", i, n_ur, n_dv, n_occ, n_dd, 32'h1111_0000 + DW'(i - 1)); else n_pass++;
      tick();
    end
    n_uv = 1'b0;
    tick();
    #1;
    n_checks++; if (n_occ !== 2'd0) $display("FAIL ns_drain: got occ=%0d expected 0", n_occ); else n_pass++;
  endtask

  task automatic test_saturation();
    idle_inputs();
    s_uv = 1'b1; s_data = 32'h5A7_0001; n_uv = 1'b1; n_data = 32'h5A7_0002;
    tick();
    s_uv = 1'b0; n_uv = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    #1;
    n_checks++; if (s_cnt !== 4'hF) $display("FAIL sat_skid: got %h expected f", s_cnt); else n_pass++;
    n_checks++; if (n_cnt !== 4'hF) $display("FAIL sat_noskid: got %h expected f", n_cnt); else n_pass++;
    n_checks++; if ({s_dv, s_dd, n_dv, n_dd} !== {1'b1, 32'h5A7_0001, 1'b1, 32'h5A7_0002}) $display("FAIL sat_hold: got sv=%b sd=%h nv=%b nd=%h expected held payloads", s_dv, s_dd, n_dv, n_dd); else n_pass++;
    s_dr = 1'b1; n_dr = 1'b1;
    tick();
    #1;
    n_checks++; if ({s_cnt, n_cnt} !== 8'hFF) $display("FAIL sat_no_wrap: got %h expected ff", {s_cnt, n_cnt}); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      s_flush = ($urandom_range(0, 15) == 0);
      s_uv    = ($urandom_range(0, 9) < 7);
      s_dr    = ($urandom_range(0, 9) < 6);
      s_data  = $urandom();
      n_flush = ($urandom_range(0, 15) == 0);
      n_uv    = ($urandom_range(0, 9) < 7);
      n_dr    = ($urandom_range(0, 9) < 6);
      n_data  = $urandom();
      #1;
      n_checks++; if ({s_ur, s_dv, s_occ} !== {exp_ready(1'b1), sq.size() > 0, 2'(sq.size())}) $display("FAIL rnd_skid_ctrl[%0d]: got ur=%b v=%b occ=%0d expected ur=%b v=%b occ=%0d", k, s_ur, s_dv, s_occ, exp_ready(1'b1), sq.size() > 0, sq.size()); else n_pass++;
      n_checks++; if ({n_ur, n_dv, n_occ} !== {exp_ready(1'b0), nq.size() > 0, 2'(nq.size())}) $display("FAIL rnd_noskid_ctrl[%0d]: got ur=%b v=%b occ=%0d expected ur=%b v=%b occ=%0d", k, n_ur, n_dv, n_occ, exp_ready(1'b0), nq.size() > 0, nq.size()); else n_pass++;
      n_checks++; if ({s_cnt, n_cnt} !== {CNT_W'(sc), CNT_W'(nc)}) $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", k, s_cnt, n_cnt, sc, nc); else n_pass++;
      if (sq.size() > 0) begin
        n_checks++; if (s_dd !== sq[0]) $display("FAIL rnd_skid_data[%0d]: got %h expected %h", k, s_dd, sq[0]); else n_pass++;
      end
      if (nq.size() > 0) begin
        n_checks++; if (n_dd !== nq[0]) $display("FAIL rnd_noskid_data[%0d]: got %h expected %h", k, n_dd, nq[0]); else n_pass++;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_noskid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
